dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  MEM-stage data cache: direct-mapped, write-back, write-allocate, between EXMEM register and MEMWB register.
//  Consumes EXMEM ALUout/ALUrtdata/memread/memwrite; returns load data to MEMWB dmdata_i.
//  Drives stall_o to freeze all pipeline registers and PC during a miss.
//  Refills and evicts whole lines through a req/ack handshake to slow data memory.
// PARAMETERS
//  NUM_LINES  32   cache lines; index = log2(NUM_LINES) = 5 bits
//  LINE_BITS  256  line size (32 B, 8 words); offset = 5 bits
//  ADDR_W     32   byte address width; tag = ADDR_W-10 = 22 bits
// PORTS
//  clk_i        in   1    clock; all state on rising edge
//  rst_i        in   1    async reset, active-high
//  memread_i    in   1    load request (EXMEM memread_o)
//  memwrite_i   in   1    store request (EXMEM memwrite_o)
//  addr_i       in   32   byte address (EXMEM ALUout_o); bits[1:0] ignored
//  wdata_i      in   32   store data (EXMEM ALUrtdata_o)
//  rdata_o      out  32   load data to MEMWB dmdata_i
//  stall_o      out  1    1 = hold pipeline this cycle
//  mem_enable_o out  1    memory request valid
//  mem_write_o  out  1    1 = line write (evict), 0 = line read (refill)
//  mem_addr_o   out  32   line-aligned address, bits[4:0] = 0
//  mem_data_o   out  256  evicted line
//  mem_data_i   in   256  refill line, valid with mem_ack_i
//  mem_ack_i    in   1    one-cycle pulse: request complete
// BEHAVIOUR
//  Address split: tag=addr[31:10], index=addr[9:5], word=addr[4:2].
//  req = memread_i | memwrite_i; both high is a store (write wins).
//  hit = req & valid[index] & (tag_arr[index]==tag), combinational.
//  stall_o = req & ~hit, combinational; also 1 in every non-IDLE state.
//  rdata_o = selected word of line on hit, else 32'b0; valid same cycle (0 extra latency on hit).
//  Write hit: at posedge, word[word] <= wdata_i, dirty[index] <= 1; no stall.
//  FSM states: IDLE, WRITEBACK, ALLOCATE.
//   IDLE: req & ~hit & valid & dirty -> WRITEBACK; req & ~hit otherwise -> ALLOCATE.
//   WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={old tag,index,5'b0},
//     mem_data_o = resident line; hold until mem_ack_i -> ALLOCATE.
//   ALLOCATE: mem_enable_o=1, mem_write_o=0, mem_addr_o={tag,index,5'b0};
//     on mem_ack_i: line<=mem_data_i, tag<=tag, valid<=1, dirty<=0 -> IDLE.
//  Miss retries in IDLE the cycle after refill as a hit; store then merges and sets dirty.
//  Miss penalty = 1 + memory latency (+ evict latency if dirty) cycles of stall_o.
//  Request outputs held stable between issue and ack; ack outside WRITEBACK/ALLOCATE ignored.
//  Pipeline inputs held constant while stall_o=1 (pipeline frozen); not re-sampled.
//  Reset (any time, incl. mid-miss): state=IDLE, all valid/dirty=0, mem_enable_o=0,
//   mem_write_o=0, mem_addr_o=0, mem_data_o=0, stall_o=0 (no req). Tags/data not cleared.
//   An in-flight memory transaction is abandoned; memory must tolerate this.
//  No req in IDLE: no state change, mem_enable_o=0.
// STRUCTURE
//  cache_pkg: state enum {IDLE,WRITEBACK,ALLOCATE}, TAG_W/IDX_W/OFF_W/WORD_SEL_W constants,
//   address-field extraction functions.
//  Sub-module dcache_sram: tag/valid/dirty/data arrays, async read, sync write,
//   async clear of valid/dirty on rst_i. Controller holds FSM, hit logic, word merge.
// TESTING
//  1 Cold load addr 0x0000_0040, memory line word0=0xDEADBEEF, ack after 5 cycles ->
//    ALLOCATE, stall_o 6 cycles, then rdata_o=0xDEADBEEF, stall_o=0.
//  2 Repeat load 0x40 -> hit, stall_o=0 same cycle, mem_enable_o never asserted.
//  3 Store 0x12345678 to 0x44 (hit) then load 0x44 -> rdata_o=0x12345678, dirty[2]=1, no stall.
//  4 Load 0x0000_0440 (same index 2, new tag) -> WRITEBACK with mem_addr_o=0x40,
//    mem_data_o word1=0x12345678, then ALLOCATE mem_addr_o=0x440, then hit.
//  5 Assert rst_i during ALLOCATE before ack -> next cycle IDLE, mem_enable_o=0;
//    reload 0x40 misses again (valid cleared).
//  6 memread_i=memwrite_i=1 to 0x80, wdata 0xA5A5A5A5 -> treated as store, line dirty, value readable.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types, geometry constants and address-field helpers for the MEM-stage data cache.
`timescale 1ns/1ps
package cache_pkg;

    localparam int ADDR_W         = 32;
    localparam int NUM_LINES      = 32;
    localparam int LINE_BITS      = 256;
    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = LINE_BITS / WORD_W;

    localparam int IDX_W      = $clog2(NUM_LINES);
    localparam int OFF_W      = $clog2(LINE_BITS / 8);
    localparam int WORD_SEL_W = $clog2(WORDS_PER_LINE);
    localparam int TAG_W      = ADDR_W - IDX_W - OFF_W;
    localparam int BYTE_SEL_W = OFF_W - WORD_SEL_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    typedef logic [TAG_W-1:0]      tag_t;
    typedef logic [IDX_W-1:0]      idx_t;
    typedef logic [WORD_SEL_W-1:0] word_sel_t;
    typedef logic [LINE_BITS-1:0]  line_t;
    typedef logic [ADDR_W-1:0]     addr_t;

    function automatic tag_t addr_tag(input addr_t addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic idx_t addr_index(input addr_t addr);
        return addr[OFF_W +: IDX_W];
    endfunction

    function automatic word_sel_t addr_word(input addr_t addr);
        return addr[BYTE_SEL_W +: WORD_SEL_W];
    endfunction

    // Rebuilds the line-aligned memory address of a line from its tag and index.
    function automatic addr_t line_addr(input tag_t tag, input idx_t idx);
        return {tag, idx, {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the direct-mapped cache.
// Combinational read of the addressed entry, single synchronous write port.
`timescale 1ns/1ps
module dcache_sram
    import cache_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  idx_t  idx,
    output tag_t  rd_tag,
    output line_t rd_data,
    output logic  rd_valid,
    output logic  rd_dirty,
    input  logic  we,
    input  tag_t  wr_tag,
    input  line_t wr_data,
    input  logic  wr_dirty
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    tag_t                 tag_q  [NUM_LINES];
    line_t                data_q [NUM_LINES];

    // Status bits: reset forgets every resident line; any write leaves the entry valid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= wr_dirty;
        end
    end

    // Tag and data storage.
    // NOTE: arrays carry no reset; valid_q masks stale contents and a reset would keep them out of RAM.
    always_ff @(posedge clk_i) begin
        if (we) begin
            tag_q[idx]  <= wr_tag;
            data_q[idx] <= wr_data;
        end
    end

    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];
    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage data cache controller: direct-mapped, write-back, write-allocate.
// Hits complete in the same cycle; misses freeze the pipeline while the line is
// evicted (if dirty) and refilled through a req/ack handshake to slow memory.
`timescale 1ns/1ps
module dcache_ctrl
    import cache_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 memread_i,
    input  logic                 memwrite_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [WORD_W-1:0]    wdata_i,
    output logic [WORD_W-1:0]    rdata_o,
    output logic                 stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    state_t    state;
    tag_t      req_tag;
    idx_t      req_idx;
    word_sel_t req_word;
    logic      req;
    logic      hit;

    tag_t      rd_tag;
    line_t     rd_data;
    logic      rd_valid;
    logic      rd_dirty;

    logic      we;
    tag_t      wr_tag;
    line_t     wr_data;
    logic      wr_dirty;

    // Byte-within-word bits play no part in a word-wide cache.
    logic      unused_byte_sel;
    assign unused_byte_sel = ^addr_i[BYTE_SEL_W-1:0];

    assign req_tag  = addr_tag(addr_i);
    assign req_idx  = addr_index(addr_i);
    assign req_word = addr_word(addr_i);

    // A simultaneous read and write request is a store; only memwrite_i matters for direction.
    assign req     = memread_i | memwrite_i;
    assign hit     = req & rd_valid & (rd_tag == req_tag);
    assign stall_o = (state != IDLE) | (req & ~hit);
    assign rdata_o = hit ? rd_data[WORD_W*int'(req_word) +: WORD_W] : '0;

    dcache_sram u_sram (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .idx      (req_idx),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .we       (we),
        .wr_tag   (wr_tag),
        .wr_data  (wr_data),
        .wr_dirty (wr_dirty)
    );

    // Storage write port: merge a store word on a hit, or install a refilled line clean.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        we       = 1'b0;
        wr_tag   = req_tag;
        wr_data  = rd_data;
        wr_dirty = 1'b0;
        if ((state == IDLE) && hit && memwrite_i) begin
            we       = 1'b1;
            wr_dirty = 1'b1;
            wr_data[WORD_W*int'(req_word) +: WORD_W] = wdata_i;
        end else if ((state == ALLOCATE) && mem_ack_i) begin
            we      = 1'b1;
            wr_data = mem_data_i;
        end
    end

    // Miss FSM with registered memory-request outputs, held stable until acknowledged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !hit) begin
                        mem_enable_o <= 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state       <= WRITEBACK;
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= line_addr(rd_tag, req_idx);
                            mem_data_o  <= rd_data;
                        end else begin
                            state       <= ALLOCATE;
                            mem_write_o <= 1'b0;
                            mem_addr_o  <= line_addr(req_tag, req_idx);
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state       <= ALLOCATE;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= line_addr(req_tag, req_idx);
                    end
                end
                ALLOCATE: begin
                    if (mem_ack_i) begin
                        state        <= IDLE;
                        mem_enable_o <= 1'b0;
                        mem_write_o  <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    mem_enable_o <= 1'b0;
                    mem_write_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: a slow-memory responder, a golden word
// store, and scoreboards of expected load data and expected memory requests.
`timescale 1ns/1ps
module tb_dcache_ctrl;

    localparam int LAT       = 5;
    localparam int MAX_STALL = 200;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         memread_i;
    logic         memwrite_i;
    logic [31:0]  addr_i;
    logic [31:0]  wdata_i;
    logic [31:0]  rdata_o;
    logic         stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    dcache_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .memread_i    (memread_i),
        .memwrite_i   (memwrite_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .stall_o      (stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } mreq_t;

    mreq_t        req_q[$];
    logic [31:0]  load_q[$];
    logic [255:0] mem_model [logic [31:0]];
    logic [31:0]  golden    [logic [31:0]];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Initial memory image: 0x40 word0 is 0xDEADBEEF, everything else address-derived.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return 32'hC0DE_0000 ^ a;
    endfunction

    function automatic logic [255:0] init_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = init_word(la + 32'(4*i));
        return l;
    endfunction

    function automatic logic [31:0] gold_word(input logic [31:0] a);
        logic [31:0] wa;
        wa = a & ~32'h3;
        if (golden.exists(wa)) return golden[wa];
        return init_word(wa);
    endfunction

    function automatic logic [255:0] gold_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = gold_word(la + 32'(4*i));
        return l;
    endfunction

    function automatic mreq_t mk_req(input logic wr, input logic [31:0] a, input logic [255:0] d);
        mreq_t r;
        r.wr   = wr;
        r.addr = a;
        r.data = d;
        return r;
    endfunction

    // Slow memory: acknowledges each request on its LAT-th cycle and checks it against the scoreboard.
    int          mcnt = 0;
    logic [31:0] held_addr;
    always @(negedge clk_i) begin
        mreq_t e;
        mem_ack_i = 1'b0;
        if (rst_i || !mem_enable_o) begin
            mcnt = 0;
        end else begin
            mcnt++;
            if (mcnt == 1) begin
                held_addr = mem_addr_o;
                check("mem_req_expected", 256'(req_q.size() != 0), 256'(1));
                if (req_q.size() != 0) begin
                    e = req_q.pop_front();
                    check("mem_write", 256'(mem_write_o), 256'(e.wr));
                    check("mem_addr", 256'(mem_addr_o), 256'(e.addr));
                    if (e.wr) check("mem_data", mem_data_o, e.data);
                end
            end
            if (mcnt == LAT) begin
                check("mem_addr_held", 256'(mem_addr_o), 256'(held_addr));
                mem_ack_i = 1'b1;
                if (mem_write_o) mem_model[mem_addr_o] = mem_data_o;
                else mem_data_i = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o]
                                                                : init_line(mem_addr_o);
                mcnt = 0;
            end
        end
    end

    // One pipeline access: drive, count stall cycles, then compare load data on release.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input int exp_stall, input string tag);
        int cyc;
        cyc = 0;
        @(posedge clk_i);
        #1;
        memread_i  = rd;
        memwrite_i = wr;
        addr_i     = a;
        wdata_i    = wd;
        if (wr) golden[a & ~32'h3] = wd;
        else    load_q.push_back(gold_word(a));
        @(negedge clk_i);
        while (stall_o && cyc < MAX_STALL) begin
            cyc++;
            @(negedge clk_i);
        end
        check({tag, "_stall"}, 256'(cyc), 256'(exp_stall));
        if (!wr) check({tag, "_rdata"}, 256'(rdata_o), 256'(load_q.pop_front()));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_stall"},  256'(stall_o), '0);
        check({tag, "_en"},     256'(mem_enable_o), '0);
        check({tag, "_wr"},     256'(mem_write_o), '0);
        check({tag, "_addr"},   256'(mem_addr_o), '0);
        check({tag, "_mdata"},  mem_data_o, '0);
        check({tag, "_rdata"},  256'(rdata_o), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i      = 1'b1;
        memread_i  = 1'b0;
        memwrite_i = 1'b0;
        addr_i     = '0;
        wdata_i    = '0;
        mem_data_i = '0;
        mem_ack_i  = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_idle_outputs("reset");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // 1: cold load allocates, 1 + LAT stall cycles.
        req_q.push_back(mk_req(1'b0, 32'h40, '0));
        access(1'b1, 1'b0, 32'h40, '0, 1 + LAT, "t1_cold");

        // 2: repeat load hits with no memory traffic.
        access(1'b1, 1'b0, 32'h40, '0, 0, "t2_hit");
        check("t2_no_mem", 256'(mem_enable_o), '0);

        // 3: store hit then load back.
        access(1'b0, 1'b1, 32'h44, 32'h12345678, 0, "t3_store");
        access(1'b1, 1'b0, 32'h44, '0, 0, "t3_load");
        access(1'b1, 1'b0, 32'h40, '0, 0, "t3_load_w0");

        // 4: conflict miss on dirty line: evict 0x40 then refill 0x440.
        req_q.push_back(mk_req(1'b1, 32'h40, gold_line(32'h40)));
        req_q.push_back(mk_req(1'b0, 32'h440, '0));
        access(1'b1, 1'b0, 32'h440, '0, 1 + 2*LAT, "t4_evict");
        access(1'b1, 1'b0, 32'h444, '0, 0, "t4_hit");

        // 5: reset in the middle of a refill abandons it and clears valid.
        req_q.push_back(mk_req(1'b0, 32'h40, '0));
        @(posedge clk_i);
        #1;
        memread_i  = 1'b1;
        memwrite_i = 1'b0;
        addr_i     = 32'h40;
        @(negedge clk_i);
        check("t5_miss_stall", 256'(stall_o), 256'(1));
        @(negedge clk_i);
        check("t5_alloc_en", 256'(mem_enable_o), 256'(1));
        #1;
        rst_i     = 1'b1;
        memread_i = 1'b0;
        #1;
        check_idle_outputs("t5_reset");
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        req_q.push_back(mk_req(1'b0, 32'h40, '0));
        access(1'b1, 1'b0, 32'h40, '0, 1 + LAT, "t5_reload");
        access(1'b1, 1'b0, 32'h44, '0, 0, "t5_reload_w1");

        // 6: read+write together is a store; line ends dirty and readable.
        req_q.push_back(mk_req(1'b0, 32'h80, '0));
        access(1'b1, 1'b1, 32'h80, 32'hA5A5A5A5, 1 + LAT, "t6_rw");
        access(1'b1, 1'b0, 32'h80, '0, 0, "t6_load");
        access(1'b1, 1'b0, 32'h84, '0, 0, "t6_load_w1");
        req_q.push_back(mk_req(1'b1, 32'h80, gold_line(32'h80)));
        req_q.push_back(mk_req(1'b0, 32'h480, '0));
        access(1'b1, 1'b0, 32'h480, '0, 1 + 2*LAT, "t6_evict");

        @(posedge clk_i);
        #1;
        memread_i  = 1'b0;
        memwrite_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("end_idle_stall", 256'(stall_o), '0);
        check("end_idle_en", 256'(mem_enable_o), '0);
        check("end_req_q_empty", 256'(req_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
